// File: rtl/stage_ex_pkg.sv
// stage_ex_pkg: opcodes, result classes and divider states for the execute stage
package stage_ex_pkg;
    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
    localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_MUL   = 3'b101;
    typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_RUN = 2'd1, DIV_DONE = 2'd2} div_state_t;
    function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
        return (s && x[31]) ? -x : x;
    endfunction
endpackage

// File: rtl/stage_ex_div.sv
// ex_div: 32-step restoring signed/unsigned divider with sign correction in DONE
module ex_div
    import stage_ex_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    div_state_t state;
    logic [5:0] cnt;
    logic [31:0] quo, rem, dvs;
    logic neg_q, neg_r;
    logic [32:0] sh;
    always_comb begin
        sh = {rem, quo[31]};
        busy = (state == DIV_IDLE && start) || state == DIV_RUN;
        done = state == DIV_DONE;
        quotient = neg_q ? -quo : quo;
        remainder = neg_r ? -rem : rem;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            dvs <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: if (start) begin
                    // divide by zero skips iteration: quotient all ones, remainder = dividend
                    if (divisor == '0) begin
                        quo <= '1;
                        rem <= dividend;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= DIV_DONE;
                    end else begin
                        quo <= mag(dividend, signed_div);
                        rem <= '0;
                        dvs <= mag(divisor, signed_div);
                        neg_q <= signed_div && (dividend[31] ^ divisor[31]);
                        neg_r <= signed_div && dividend[31];
                        cnt <= '0;
                        state <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    if (sh >= {1'b0, dvs}) begin
                        rem <= 32'(sh - {1'b0, dvs});
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= sh[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(DIV_CYCLES - 1)) state <= DIV_DONE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/stage_ex.sv
// stage_ex: MIPS execute stage; logic/shift/move/multiply results and divider control
module stage_ex
    import stage_ex_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop,
    input  logic [2:0]  alusel,
    input  logic [31:0] opv1,
    input  logic [31:0] opv2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic        mem_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic        wb_whilo,
    input  logic [31:0] wb_hi,
    input  logic [31:0] wb_lo,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq
);
    logic [31:0] fhi, flo, logic_res, shift_res, move_res, quo, rem;
    logic [63:0] prod;
    logic is_div, is_mul, is_mthi, is_mtlo, div_busy, div_done, div_out;
    always_comb begin
        fhi = mem_whilo ? mem_hi : wb_whilo ? wb_hi : hi;
        flo = mem_whilo ? mem_lo : wb_whilo ? wb_lo : lo;
        logic_res = aluop == EXE_OR_OP  ? opv1 | opv2 :
                    aluop == EXE_AND_OP ? opv1 & opv2 :
                    aluop == EXE_XOR_OP ? opv1 ^ opv2 :
                    aluop == EXE_NOR_OP ? ~(opv1 | opv2) : '0;
        shift_res = aluop == EXE_SLL_OP ? opv2 << opv1[4:0] :
                    aluop == EXE_SRL_OP ? opv2 >> opv1[4:0] :
                    aluop == EXE_SRA_OP ? 32'($signed(opv2) >>> opv1[4:0]) : '0;
        move_res = aluop == EXE_MFHI_OP ? fhi :
                   aluop == EXE_MFLO_OP ? flo :
                   (aluop == EXE_MOVN_OP || aluop == EXE_MOVZ_OP) ? opv1 : '0;
        prod = aluop == EXE_MULT_OP ?
               64'($signed({{32{opv1[31]}}, opv1}) * $signed({{32{opv2[31]}}, opv2})) :
               {32'b0, opv1} * {32'b0, opv2};
        is_div = aluop == EXE_DIV_OP || aluop == EXE_DIVU_OP;
        is_mul = aluop == EXE_MULT_OP || aluop == EXE_MULTU_OP;
        is_mthi = aluop == EXE_MTHI_OP;
        is_mtlo = aluop == EXE_MTLO_OP;
        div_out = is_div && div_done;
    end
    ex_div #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk(clk),
        .rst(rst),
        .start(is_div),
        .signed_div(aluop == EXE_DIV_OP),
        .dividend(opv1),
        .divisor(opv2),
        .busy(div_busy),
        .done(div_done),
        .quotient(quo),
        .remainder(rem)
    );
    always_comb begin
        we_o = !rst && we;
        waddr_o = rst ? '0 : waddr;
        wdata_o = rst ? '0 :
                  alusel == EXE_RES_LOGIC ? logic_res :
                  alusel == EXE_RES_SHIFT ? shift_res :
                  alusel == EXE_RES_MOVE  ? move_res :
                  alusel == EXE_RES_MUL   ? prod[31:0] : '0;
        whilo_o = !rst && (is_mul || is_mthi || is_mtlo || div_out);
        hi_o = rst ? '0 : is_mul ? prod[63:32] : is_mthi ? opv1 : is_mtlo ? fhi : div_out ? rem : '0;
        lo_o = rst ? '0 : is_mul ? prod[31:0] : is_mtlo ? opv1 : is_mthi ? flo : div_out ? quo : '0;
        stallreq = !rst && div_busy;
    end
endmodule

// File: tb/tb_stage_ex.sv
// tb_stage_ex: directed and random checks of stage_ex against an arithmetic reference model
module tb_stage_ex;
    import stage_ex_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] aluop = '0;
    logic [2:0] alusel = '0;
    logic [31:0] opv1 = '0, opv2 = '0, hi = '0, lo = '0, mem_hi = '0, mem_lo = '0, wb_hi = '0, wb_lo = '0;
    logic we = 1'b0, mem_whilo = 1'b0, wb_whilo = 1'b0;
    logic [4:0] waddr = '0;
    logic we_o, whilo_o, stallreq;
    logic [4:0] waddr_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    int passed = 0, total = 0;
    logic [7:0] ops [14];
    logic [2:0] sels [14];

    stage_ex dut (
        .clk(clk), .rst(rst), .aluop(aluop), .alusel(alusel), .opv1(opv1), .opv2(opv2),
        .we(we), .waddr(waddr), .hi(hi), .lo(lo),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // reference semantics for single-cycle operations
    task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] wd, output logic wh, output logic [31:0] eh, output logic [31:0] el);
        logic [31:0] fh, fl;
        logic [63:0] p;
        fh = hi; fl = lo;
        if (wb_whilo) begin fh = wb_hi; fl = wb_lo; end
        if (mem_whilo) begin fh = mem_hi; fl = mem_lo; end
        wd = '0; wh = 1'b0; eh = '0; el = '0;
        case (op)
            EXE_OR_OP:   wd = a | b;
            EXE_AND_OP:  wd = a & b;
            EXE_XOR_OP:  wd = a ^ b;
            EXE_NOR_OP:  wd = ~(a | b);
            EXE_SLL_OP:  wd = b << a[4:0];
            EXE_SRL_OP:  wd = b >> a[4:0];
            EXE_SRA_OP:  wd = 32'($signed(b) >>> a[4:0]);
            EXE_MFHI_OP: wd = fh;
            EXE_MFLO_OP: wd = fl;
            EXE_MOVN_OP, EXE_MOVZ_OP: wd = a;
            EXE_MTHI_OP: begin wh = 1'b1; eh = a; el = fl; end
            EXE_MTLO_OP: begin wh = 1'b1; eh = fh; el = a; end
            EXE_MULT_OP: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                wh = 1'b1; eh = p[63:32]; el = p[31:0];
            end
            EXE_MULTU_OP: begin
                p = 64'(a) * 64'(b);
                wh = 1'b1; eh = p[63:32]; el = p[31:0];
            end
            default: ;
        endcase
    endtask

    task automatic check_comb(input string tag);
        logic [31:0] wd, eh, el;
        logic wh;
        model(aluop, opv1, opv2, wd, wh, eh, el);
        chk({tag, ".wdata"}, 64'(wdata_o), 64'(wd));
        chk({tag, ".whilo"}, 64'(whilo_o), 64'(wh));
        chk({tag, ".hi"}, 64'(hi_o), 64'(eh));
        chk({tag, ".lo"}, 64'(lo_o), 64'(el));
    endtask

    task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        logic [31:0] eq, er;
        aluop = op; alusel = EXE_RES_NOP; opv1 = a; opv2 = b;
        if (b == 0) begin eq = '1; er = a; end
        else if (op == EXE_DIV_OP) begin eq = 32'($signed(a) / $signed(b)); er = 32'($signed(a) % $signed(b)); end
        else begin eq = a / b; er = a % b; end
        #1;
        n = 0;
        while (stallreq && n < 40) begin
            chk({tag, ".whilo_busy"}, 64'(whilo_o), 64'(0));
            n++;
            tick;
        end
        chk({tag, ".stall_cycles"}, 64'(n), 64'(b == 0 ? 1 : 33));
        chk({tag, ".done_whilo"}, 64'(whilo_o), 64'(1));
        chk({tag, ".quotient"}, 64'(lo_o), 64'(eq));
        chk({tag, ".remainder"}, 64'(hi_o), 64'(er));
        aluop = EXE_NOP_OP;
        #1;
        chk({tag, ".after_whilo"}, 64'(whilo_o), 64'(0));
        tick;
    endtask

    initial begin
        ops  = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
                 EXE_MFHI_OP, EXE_MFLO_OP, EXE_MOVN_OP, EXE_MTHI_OP, EXE_MTLO_OP, EXE_MULT_OP, EXE_MULTU_OP};
        sels = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_SHIFT,
                 EXE_RES_SHIFT, EXE_RES_MOVE, EXE_RES_MOVE, EXE_RES_MOVE, EXE_RES_NOP, EXE_RES_NOP,
                 EXE_RES_NOP, EXE_RES_NOP};
        // reset holds every output low, even with a live OR and a divide-class op
        aluop = EXE_OR_OP; alusel = EXE_RES_LOGIC; opv1 = 32'h1234; opv2 = 32'h5678; we = 1'b1; waddr = 5'd9;
        tick;
        chk("rst.wdata", 64'(wdata_o), 64'(0));
        chk("rst.we", 64'(we_o), 64'(0));
        chk("rst.waddr", 64'(waddr_o), 64'(0));
        aluop = EXE_DIV_OP; opv2 = 32'd3;
        #1;
        chk("rst.stall", 64'(stallreq), 64'(0));
        chk("rst.whilo", 64'(whilo_o), 64'(0));
        tick;
        rst = 1'b0;
        aluop = EXE_OR_OP; alusel = EXE_RES_LOGIC; opv1 = 32'h0000_1100; opv2 = 32'h0000_0020; we = 1'b1; waddr = 5'd5;
        #1;
        chk("ori.wdata", 64'(wdata_o), 64'h1120);
        chk("ori.we", 64'(we_o), 64'(1));
        chk("ori.waddr", 64'(waddr_o), 64'(5));
        aluop = EXE_SRA_OP; alusel = EXE_RES_SHIFT; opv1 = 32'd4; opv2 = 32'h8000_0000;
        #1;
        chk("sra", 64'(wdata_o), 64'hF800_0000);
        aluop = EXE_SRL_OP;
        #1;
        chk("srl", 64'(wdata_o), 64'h0800_0000);
        hi = 32'd1; wb_whilo = 1'b1; wb_hi = 32'd2; mem_whilo = 1'b1; mem_hi = 32'd3;
        aluop = EXE_MFHI_OP; alusel = EXE_RES_MOVE;
        #1;
        chk("mfhi.mem", 64'(wdata_o), 64'(3));
        mem_whilo = 1'b0;
        #1;
        chk("mfhi.wb", 64'(wdata_o), 64'(2));
        wb_whilo = 1'b0;
        aluop = EXE_MULT_OP; alusel = EXE_RES_NOP; opv1 = -32'sd3; opv2 = 32'd5;
        #1;
        chk("mult.hi", 64'(hi_o), 64'hFFFF_FFFF);
        chk("mult.lo", 64'(lo_o), 64'hFFFF_FFF1);
        chk("mult.whilo", 64'(whilo_o), 64'(1));
        aluop = EXE_MULTU_OP;
        #1;
        chk("multu.hi", 64'(hi_o), 64'(4));
        chk("multu.lo", 64'(lo_o), 64'hFFFF_FFF1);
        tick;
        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(13, 0);
            aluop = ops[k]; alusel = sels[k];
            opv1 = $urandom; opv2 = $urandom; hi = $urandom; lo = $urandom;
            mem_hi = $urandom; mem_lo = $urandom; wb_hi = $urandom; wb_lo = $urandom;
            mem_whilo = 1'($urandom); wb_whilo = 1'($urandom);
            #1;
            check_comb($sformatf("rand%0d_op%0h", i, ops[k]));
            chk("rand.stall", 64'(stallreq), 64'(0));
            tick;
        end
        do_div(EXE_DIV_OP, -32'sd7, 32'd2, "div_m7_2");
        do_div(EXE_DIVU_OP, 32'hDEAD_BEEF, 32'd0, "divu_zero");
        do_div(EXE_DIV_OP, 32'h8000_0000, 32'd0, "div_zero");
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 2) ? $urandom : 32'($urandom_range(1000, 1));
            if (b == 0 || (a == 32'h8000_0000 && b == '1)) b = 32'd7;
            do_div((i < 3) ? EXE_DIV_OP : EXE_DIVU_OP, a, b, $sformatf("div_rand%0d", i));
        end
        aluop = EXE_DIV_OP; opv1 = 32'd100; opv2 = 32'd3;
        #1;
        repeat (11) tick;
        chk("midrun.stall", 64'(stallreq), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrun.rst_stall", 64'(stallreq), 64'(0));
        tick;
        rst = 1'b0;
        aluop = EXE_NOP_OP; alusel = EXE_RES_NOP;
        #1;
        chk("post_rst.stall", 64'(stallreq), 64'(0));
        chk("post_rst.whilo", 64'(whilo_o), 64'(0));
        tick;
        do_div(EXE_DIV_OP, 32'd100, -32'sd3, "div_after_rst");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
